// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the multicycle fp16 datapath.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    localparam logic signed [6:0] BIAS = 7'sd15;
    localparam logic [15:0]       QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MULT,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 operand classifier: sign, class and hidden-bit mantissa.
// Subnormals are reported as zero.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]       value,
    output logic              sign,
    output fp_class_t         cls,
    output logic [MANT_W-1:0] mant
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;

    assign sign  = value[15];
    assign exp_f = value[14:10];
    assign frac  = value[9:0];

    always_comb begin
        cls  = CLS_NORM;
        mant = {1'b1, frac};
        if (exp_f == '1) begin
            cls = (frac != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_f == '0) begin
            cls  = CLS_ZERO;
            mant = '0;
        end
    end

endmodule

// File: rtl/fp16_seq_mul.sv
// Multicycle binary16 multiplier with an 11-step shift-add mantissa loop, fixed latency.
// Define FP16_RNE_EN to round to nearest even; otherwise the product is truncated.
//
// state  | meaning
// IDLE   | waiting for start, operands latched on accept
// UNPACK | sign, exponent sum and operand classes registered
// MULT   | one shift-add step per cycle, cnt 0..10
// NORM   | normalise, round, apply special/overflow/underflow, register result
// DONE   | done pulse for one cycle
module fp16_seq_mul
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        nv
);

    state_t state, state_next;

    logic [15:0]        a_q, b_q;
    logic               sign_a, sign_b, sign_q;
    fp_class_t          cls_a, cls_b, cls_a_q, cls_b_q;
    logic [MANT_W-1:0]  mant_a, mant_b;
    logic signed [6:0]  exp_q;
    logic [PROD_W-1:0]  acc_q, mcand_q;
    logic [MANT_W-1:0]  mplier_q;
    logic [3:0]         cnt_q;

    logic signed [6:0]  exp_n;
    logic [FRAC_W-1:0]  frac_n;
    logic [15:0]        res_n;
    logic               ovf_n, unf_n, nv_n;
    logic               any_nan, any_inf, any_zero;
`ifdef FP16_RNE_EN
    logic               guard_b, round_b, sticky_b;
    logic [FRAC_W:0]    frac_r;
`endif

    fp16_classify u_cls_a (.value(a_q), .sign(sign_a), .cls(cls_a), .mant(mant_a));
    fp16_classify u_cls_b (.value(b_q), .sign(sign_b), .cls(cls_b), .mant(mant_b));

    assign busy = (state == ST_UNPACK) || (state == ST_MULT) || (state == ST_NORM);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_UNPACK;
            ST_UNPACK: state_next = ST_MULT;
            ST_MULT:   if (cnt_q == 4'(MANT_W - 1)) state_next = ST_NORM;
            ST_NORM:   state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Product of two 1.x mantissas lies in [1,4): bit 21 or bit 20 is the leading one.
    always_comb begin
        exp_n  = exp_q;
        frac_n = acc_q[19:10];
        if (acc_q[PROD_W-1]) begin
            exp_n  = exp_q + 7'sd1;
            frac_n = acc_q[20:11];
        end
`ifdef FP16_RNE_EN
        guard_b  = acc_q[PROD_W-1] ? acc_q[10] : acc_q[9];
        round_b  = acc_q[PROD_W-1] ? acc_q[9]  : acc_q[8];
        sticky_b = acc_q[PROD_W-1] ? |acc_q[8:0] : |acc_q[7:0];
        frac_r   = {1'b0, frac_n} + {{FRAC_W{1'b0}}, guard_b & (round_b | sticky_b | frac_n[0])};
        frac_n   = frac_r[FRAC_W-1:0];
        if (frac_r[FRAC_W]) exp_n = exp_n + 7'sd1;
`endif
        any_nan  = (cls_a_q == CLS_NAN)  || (cls_b_q == CLS_NAN);
        any_inf  = (cls_a_q == CLS_INF)  || (cls_b_q == CLS_INF);
        any_zero = (cls_a_q == CLS_ZERO) || (cls_b_q == CLS_ZERO);
        nv_n  = 1'b0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        res_n = {sign_q, exp_n[EXP_W-1:0], frac_n};
        if (any_nan || (any_inf && any_zero)) begin
            res_n = QNAN;
            nv_n  = 1'b1;
        end else if (any_inf) begin
            res_n = {sign_q, 5'h1F, 10'h000};
        end else if (any_zero) begin
            res_n = {sign_q, 15'h0000};
        end else if (exp_n >= 7'sd31) begin
            res_n = {sign_q, 5'h1F, 10'h000};
            ovf_n = 1'b1;
        end else if (exp_n <= 7'sd0) begin
            res_n = {sign_q, 15'h0000};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            cls_a_q  <= CLS_ZERO;
            cls_b_q  <= CLS_ZERO;
            exp_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            nv       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                ST_UNPACK: begin
                    sign_q   <= sign_a ^ sign_b;
                    cls_a_q  <= cls_a;
                    cls_b_q  <= cls_b;
                    exp_q    <= $signed({2'b00, a_q[14:10]}) + $signed({2'b00, b_q[14:10]}) - BIAS;
                    acc_q    <= '0;
                    mcand_q  <= {{MANT_W{1'b0}}, mant_a};
                    mplier_q <= mant_b;
                    cnt_q    <= '0;
                end
                ST_MULT: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                end
                ST_NORM: begin
                    result <= res_n;
                    ovf    <= ovf_n;
                    unf    <= unf_n;
                    nv     <= nv_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_seq_mul.sv
// Self-checking bench for fp16_seq_mul: directed cases, protocol corners and random operands
// against an arithmetic reference model.
module tb_fp16_seq_mul;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done, ovf, unf, nv;
    logic [15:0] result;

    int n_checks = 0;
    int n_errors = 0;

    fp16_seq_mul dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .unf(unf), .nv(nv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Returns {nv, ovf, unf, result}.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, fx, fy, e, p, q, shift;
        bit nx, ny, ix, iy, zx, zy;
        logic s;
        ex = int'(x[14:10]); fx = int'(x[9:0]);
        ey = int'(y[14:10]); fy = int'(y[9:0]);
        nx = (ex == 31) && (fx != 0);  ny = (ey == 31) && (fy != 0);
        ix = (ex == 31) && (fx == 0);  iy = (ey == 31) && (fy == 0);
        zx = (ex == 0);                zy = (ey == 0);
        s  = x[15] ^ y[15];
        if (nx || ny || ((ix || iy) && (zx || zy))) return {3'b100, 16'h7E00};
        if (ix || iy) return {3'b000, s, 15'h7C00};
        if (zx || zy) return {3'b000, s, 15'h0000};
        p = (1024 + fx) * (1024 + fy);
        shift = (p >= (1 << 21)) ? 11 : 10;
        q = p >> shift;
        e = ex + ey - 15 + (shift - 10);
`ifdef FP16_RNE_EN
        begin
            int rem, half;
            rem  = p - (q << shift);
            half = 1 << (shift - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end
`endif
        if (e >= 31) return {3'b010, s, 15'h7C00};
        if (e <= 0)  return {3'b001, s, 15'h0000};
        return {3'b000, s, 5'(e), 10'(q % 1024)};
    endfunction

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input bit poke,
                          input logic [18:0] want);
        int cyc, busy_n;
        bit got;
        start = 1'b1; a = op_a; b = op_b;
        cyc = 0; busy_n = 0; got = 0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 4);
            if (start) begin a = 16'h4400; b = 16'h4400; end
            if (done) got = 1;
            else if (busy) busy_n++;
        end
        chk("done_latency", 32'(cyc), 32'd14);
        chk("busy_span", 32'(busy_n), 32'd13);
        chk("result", {16'h0, result}, {16'h0, want[15:0]});
        chk("flags_nv_ovf_unf", {29'h0, nv, ovf, unf}, {29'h0, want[18:16]});
        if (poke) begin
            start = 1'b1; a = 16'h4400; b = 16'h4400;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", {31'h0, done}, 32'h0);
        chk("idle_after_done", {31'h0, busy}, 32'h0);
        chk("result_held", {16'h0, result}, {16'h0, want[15:0]});
    endtask

    function automatic logic [15:0] rand_fp();
        int r;
        logic [15:0] v;
        r = int'($urandom_range(0, 9));
        case (r)
            0: begin
                v = 16'h0000;
                case ($urandom_range(0, 5))
                    0: v = 16'h0000;
                    1: v = 16'h8000;
                    2: v = 16'h7C00;
                    3: v = 16'hFC00;
                    4: v = {1'b0, 5'h1F, 10'($urandom_range(1, 1023))};
                    default: v = {1'b0, 5'h00, 10'($urandom_range(1, 1023))};
                endcase
            end
            1, 2: v = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            default: v = {1'($urandom), 5'($urandom_range(9, 21)), 10'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        int dones;
        logic [15:0] ra, rb;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_flags", {29'h0, nv, ovf, unf}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run_op(16'h3C00, 16'h4000, 0, {3'b000, 16'h4000});
        run_op(16'h3E00, 16'h3E00, 0, {3'b000, 16'h4080});
        run_op(16'hC000, 16'h3C00, 0, {3'b000, 16'hC000});
        run_op(16'h7BFF, 16'h7BFF, 0, {3'b010, 16'h7C00});
        run_op(16'h0400, 16'h0400, 0, {3'b001, 16'h0000});
        run_op(16'h0000, 16'h7C00, 0, {3'b100, 16'h7E00});
        run_op(16'h7E01, 16'h3C00, 0, {3'b100, 16'h7E00});
        run_op(16'h7C00, 16'hC000, 0, {3'b000, 16'hFC00});
`ifdef FP16_RNE_EN
        run_op(16'h3C01, 16'h3E00, 0, {3'b000, 16'h3E02});
`else
        run_op(16'h3C01, 16'h3E00, 0, {3'b000, 16'h3E01});
`endif
        // start during busy and during DONE must both be ignored
        run_op(16'h3E00, 16'h3E00, 1, {3'b000, 16'h4080});

        // reset in the middle of an operation
        start = 1'b1; a = 16'h7BFF; b = 16'h7BFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_flags", {29'h0, nv, ovf, unf}, 32'h0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_op(16'hC000, 16'h3C00, 0, {3'b000, 16'hC000});

        for (int i = 0; i < 60; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            run_op(ra, rb, 0, model(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
